// File: rtl/audio_fft_pkg.sv
// Shared types and sizes for the FFT squared-magnitude datapath.
package audio_fft_pkg;

  localparam int N_BINS = 2048;
  localparam int IN_W   = 24;
  localparam int OUT_W  = 2 * IN_W;
  localparam int BIN_W  = $clog2(N_BINS);

  typedef struct packed {
    logic signed [IN_W-1:0] im;
    logic signed [IN_W-1:0] re;
  } cplx_t;

  typedef logic [OUT_W-1:0] mag_t;
  typedef logic [BIN_W-1:0] bin_t;

  // Widen a component to product width so the square is formed without truncation.
  function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] x);
    return {{(OUT_W-IN_W){x[IN_W-1]}}, x};
  endfunction

endpackage

// File: rtl/mag_pipe_stage.sv
// Generic valid/enable register slice used for each stage of the magnitude pipeline.
module mag_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/fft_mag_calc.sv
// Three-stage re^2+im^2 pipeline with bin tagging; Axis_If ports flattened to _data/_valid/_ready.
// Define FFT_MAG_HALF_SPECTRUM_EN to emit only bins 0..N_BINS/2-1.
module fft_mag_calc
  import audio_fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [2*IN_W-1:0] fft_bins_data,
  input  logic              fft_bins_valid,
  output logic              fft_bins_ready,
  output logic [OUT_W-1:0]  fft_mag_data,
  output logic              fft_mag_valid,
  input  logic              fft_mag_ready,
  output logic [BIN_W-1:0]  mag_bin
);

  typedef struct packed {
    bin_t  bin;
    cplx_t c;
  } s1_t;

  typedef struct packed {
    bin_t bin;
    mag_t rr;
    mag_t ii;
  } s2_t;

  typedef struct packed {
    bin_t bin;
    mag_t mag;
  } s3_t;

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic accept, s1_in_valid;
  bin_t bin_cnt;
  s1_t  s1_in, s1_q;
  s2_t  s2_in, s2_q;
  s3_t  s3_in, s3_q;
  logic signed [OUT_W-1:0] re_x, im_x;

  // Handshake: a beat transfers on a rising edge where valid && ready; a stage
  // advances when it is empty or the stage after it advances, so bubbles collapse.
  assign en3            = !v3 || fft_mag_ready;
  assign en2            = !v2 || en3;
  assign en1            = !v1 || en2;
  assign fft_bins_ready = en1 && reset;
  assign accept         = fft_bins_valid && fft_bins_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt <= '0;
    end else if (accept) begin
      bin_cnt <= bin_cnt + 1'b1;
    end
  end

`ifdef FFT_MAG_HALF_SPECTRUM_EN
  // Upper-half bins are consumed and counted but never enter the pipe as valid.
  assign s1_in_valid = accept && !bin_cnt[BIN_W-1];
`else
  assign s1_in_valid = accept;
`endif

  always_comb begin
    s1_in     = '0;
    s1_in.bin = bin_cnt;
    s1_in.c   = fft_bins_data;
  end

  mag_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk(clk), .reset(reset), .en(en1),
    .in_valid(s1_in_valid), .in_data(s1_in),
    .out_valid(v1), .out_data(s1_q)
  );

  always_comb begin
    re_x      = sext(s1_q.c.re);
    im_x      = sext(s1_q.c.im);
    s2_in     = '0;
    s2_in.bin = s1_q.bin;
    s2_in.rr  = mag_t'(re_x * re_x);
    s2_in.ii  = mag_t'(im_x * im_x);
  end

  mag_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk(clk), .reset(reset), .en(en2),
    .in_valid(v1), .in_data(s2_in),
    .out_valid(v2), .out_data(s2_q)
  );

  // Each square is at most 2^(2*IN_W-2), so the sum cannot overflow OUT_W.
  always_comb begin
    s3_in     = '0;
    s3_in.bin = s2_q.bin;
    s3_in.mag = s2_q.rr + s2_q.ii;
  end

  mag_pipe_stage #(.W($bits(s3_t))) u_s3 (
    .clk(clk), .reset(reset), .en(en3),
    .in_valid(v2), .in_data(s3_in),
    .out_valid(v3), .out_data(s3_q)
  );

  assign fft_mag_valid = v3;
  assign fft_mag_data  = s3_q.mag;
  assign mag_bin       = s3_q.bin;

endmodule

// File: tb/tb_fft_mag_calc.sv
// Scoreboard bench for fft_mag_calc; honours FFT_MAG_HALF_SPECTRUM_EN when defined.
module tb_fft_mag_calc;
  import audio_fft_pkg::*;

`ifdef FFT_MAG_HALF_SPECTRUM_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [2*IN_W-1:0] bins_data = '0;
  logic              bins_valid = 1'b0;
  logic              bins_ready;
  mag_t              mag_data;
  logic              mag_valid;
  logic              mag_ready = 1'b1;
  bin_t              mag_bin;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_out  = 0;
  int n_push = 0;
  int tb_bin = 0;
  bit rnd_ready = 1'b0;
  logic [BIN_W+OUT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  fft_mag_calc dut (
    .clk(clk),
    .reset(reset),
    .fft_bins_data(bins_data),
    .fft_bins_valid(bins_valid),
    .fft_bins_ready(bins_ready),
    .fft_mag_data(mag_data),
    .fft_mag_valid(mag_valid),
    .fft_mag_ready(mag_ready),
    .mag_bin(mag_bin)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mag_t model_mag(input logic [2*IN_W-1:0] d);
    longint re, im;
    re = longint'($signed(d[IN_W-1:0]));
    im = longint'($signed(d[2*IN_W-1:IN_W]));
    return mag_t'(re * re + im * im);
  endfunction

  always @(posedge clk) begin
    #1;
    mag_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: expected ready from occupancy, in-order output compare, push on accept.
  always @(negedge clk) begin
    if (reset) begin
      check("bins_ready", {63'd0, bins_ready}, {63'd0, !(exp_q.size() >= 3 && !mag_ready)});
      if (mag_valid) begin
        check("q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          check("out", {5'd0, mag_bin, mag_data}, {5'd0, exp_q[0]});
          if (mag_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (bins_valid && bins_ready) begin
        if (!HALF || tb_bin < N_BINS / 2) begin
          exp_q.push_back({bin_t'(tb_bin), model_mag(bins_data)});
          n_push++;
        end
        tb_bin = (tb_bin + 1) % N_BINS;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    bins_valid = 1'b0;
    exp_q.delete();
    tb_bin = 0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_beat(input logic [2*IN_W-1:0] d);
    int t;
    bins_data  = d;
    bins_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bins_ready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (!bins_ready) check("accept_timeout", {63'd0, bins_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bins_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    bins_valid = 1'b0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic beat_and_check(input logic [2*IN_W-1:0] d, input mag_t exp_d, input bin_t exp_b);
    int n;
    drive_beat(d);
    bins_valid = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (mag_valid) break;
    end
    check("latency", 64'(n), 64'd3);
    check("data", {16'd0, mag_data}, {16'd0, exp_d});
    check("bin", {53'd0, mag_bin}, {53'd0, exp_b});
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, bins_ready}, 64'd0);
    check("rst_valid", {63'd0, mag_valid}, 64'd0);
    check("rst_data", {16'd0, mag_data}, 64'd0);
    check("rst_bin", {53'd0, mag_bin}, 64'd0);
    reset = 1'b1;
    idle(1);

    beat_and_check({24'd4, 24'd3}, 48'd25, 11'd0);
    beat_and_check({24'h800000, 24'h800000}, 48'h8000_0000_0000, 11'd1);
    beat_and_check({24'd0, 24'h7fffff}, 48'h3FFF_FF00_0001, 11'd2);
    drain(20);

    // Two back-to-back frames, re = bin
    apply_reset(3);
    n_out = 0;
    for (int i = 0; i < 2 * N_BINS; i++) begin
      drive_beat({24'd0, 24'(i % N_BINS)});
    end
    drain(50);
    check("frame_outs", 64'(n_out), HALF ? 64'd2048 : 64'd4096);

    // Random valid gaps and random output backpressure
    n_out = 0;
    n_push = 0;
    rnd_ready = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive_beat({24'($urandom()), 24'($urandom())});
    end
    drain(1000);
    rnd_ready = 1'b0;
    check("rand_outs", 64'(n_out), 64'(n_push));
    idle(2);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      drive_beat({24'(i + 1), 24'(i + 1)});
    end
    bins_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, mag_valid}, 64'd0);
    check("mid_rst_ready", {63'd0, bins_ready}, 64'd0);
    check("mid_rst_data", {16'd0, mag_data}, 64'd0);
    exp_q.delete();
    tb_bin = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    beat_and_check({24'd0, 24'd5}, 48'd25, 11'd0);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
